// File: rtl/acc_stack.sv
// Accumulator with a DEPTH-entry save stack for spilling/restoring across nested computations.
// Define ACC_STACK_TRISTATE_EN to float out_reg when not dumping; otherwise it idles at zero.
module acc_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             push,
    input  logic             pop,
    input  logic             dump,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out_reg,
    output logic [WIDTH-1:0] out_alu,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam int unsigned IW = $clog2(DEPTH);

    logic [WIDTH-1:0] acc, acc_d;
    logic [CW-1:0]    count_d;
    logic             err_d;
    logic             mem_we;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == CW'(0));
    assign out_alu = acc;
    assign wr_idx  = IW'(count);
    assign rd_idx  = IW'(count - CW'(1));

`ifdef ACC_STACK_TRISTATE_EN
    assign out_reg = dump ? acc : {WIDTH{1'bz}};
`else
    assign out_reg = dump ? acc : {WIDTH{1'b0}};
`endif

    // Priority-ordered request decode; illegal requests leave state untouched.
    always_comb begin
        acc_d   = acc;
        count_d = count;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        if (push && pop) begin
            err_d = 1'b1;
        end else if (push && full) begin
            err_d = 1'b1;
        end else if (pop && empty) begin
            err_d = 1'b1;
        end else if (push) begin
            mem_we  = 1'b1;
            count_d = count + CW'(1);
            if (load) begin
                acc_d = in;
            end
        end else if (pop) begin
            acc_d   = mem[rd_idx];
            count_d = count - CW'(1);
        end else if (load) begin
            acc_d = in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            acc   <= acc_d;
            count <= count_d;
            err   <= err_d;
        end
    end

    // Stack storage carries no reset; entries at or above count are never read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= acc;
        end
    end

endmodule

// File: tb/tb_acc_stack.sv
// Directed self-checking bench for acc_stack (DEPTH=4, WIDTH=8).
module tb_acc_stack;

    logic       clk;
    logic       reset;
    logic       load, push, pop, dump;
    logic [7:0] in;
    logic [7:0] out_reg, out_alu;
    logic [2:0] count;
    logic       full, empty, err;

    int checks;
    int errors;

    acc_stack #(.WIDTH(8), .DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .push    (push),
        .pop     (pop),
        .dump    (dump),
        .in      (in),
        .out_reg (out_reg),
        .out_alu (out_alu),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    logic [7:0] idle_val;

    initial begin
        checks = 0;
        errors = 0;
`ifdef ACC_STACK_TRISTATE_EN
        idle_val = 8'hzz;
`else
        idle_val = 8'h00;
`endif
        reset = 1'b0; dump = 1'b0;
        load = 1'b1; push = 1'b0; pop = 1'b0; in = 8'hAA;

        // Reset held with load active
        repeat (3) step();
        check("rst_alu",   out_alu, 8'h00);
        check("rst_count", 8'(count), 8'd0);
        check("rst_empty", 8'(empty), 8'd1);
        check("rst_full",  8'(full),  8'd0);
        check("rst_err",   8'(err),   8'd0);
        reset = 1'b1;
        step();
        check("load_aa", out_alu, 8'hAA);

        // Fill
        load = 1'b1; in = 8'd1;
        step();
        check("load_1", out_alu, 8'd1);
        for (int i = 2; i <= 5; i++) begin
            push = 1'b1; load = 1'b1; in = 8'(i);
            step();
            check("fill_count", 8'(count), 8'(i - 1));
            check("fill_alu",   out_alu,   8'(i));
        end
        idle();
        check("full_flag",  8'(full),  8'd1);
        check("full_empty", 8'(empty), 8'd0);

        // Overflow
        push = 1'b1;
        step();
        idle();
        check("ovf_err",   8'(err),   8'd1);
        check("ovf_count", 8'(count), 8'd4);
        check("ovf_alu",   out_alu,   8'd5);
        step();
        check("ovf_err_clr", 8'(err), 8'd0);

        // Drain
        for (int i = 4; i >= 1; i--) begin
            pop = 1'b1;
            step();
            check("drain_alu",   out_alu,   8'(i));
            check("drain_count", 8'(count), 8'(i - 1));
            check("drain_err",   8'(err),   8'd0);
        end
        idle();
        check("drain_empty", 8'(empty), 8'd1);

        // Underflow, held for two edges
        pop = 1'b1;
        step();
        check("udf_err1", 8'(err), 8'd1);
        check("udf_alu",  out_alu, 8'd1);
        step();
        check("udf_err2", 8'(err), 8'd1);
        idle();
        step();
        check("udf_err_clr", 8'(err), 8'd0);

        // Push+pop at count 2
        push = 1'b1; load = 1'b1; in = 8'h10;
        step();
        in = 8'h20;
        step();
        check("pp_pre_count", 8'(count), 8'd2);
        push = 1'b1; pop = 1'b1; load = 1'b0;
        step();
        idle();
        check("pp_err",   8'(err),   8'd1);
        check("pp_count", 8'(count), 8'd2);
        check("pp_alu",   out_alu,   8'h20);
        pop = 1'b1;
        step();
        check("pop_10", out_alu, 8'h10);
        pop = 1'b1; load = 1'b1; in = 8'hFF;
        step();
        idle();
        check("popld_alu",   out_alu,   8'd1);
        check("popld_err",   8'(err),   8'd0);
        check("popld_empty", 8'(empty), 8'd1);

        // Dump shows pre-edge accumulator
        load = 1'b1; in = 8'h3C;
        step();
        idle();
        dump = 1'b1;
        #1;
        check("dump_on", out_reg, 8'h3C);
        push = 1'b1; load = 1'b1; in = 8'h77;
        #2;
        check("dump_pre_edge", out_reg, 8'h3C);
        step();
        idle();
        check("dump_post_edge", out_reg, 8'h77);
        dump = 1'b0;
        #1;
        check("dump_off", out_reg, idle_val);

        // Async reset mid-sequence at count 3
        push = 1'b1;
        step();
        step();
        idle();
        check("ar_pre_count", 8'(count), 8'd3);
        #2;
        reset = 1'b0;
        #1;
        check("ar_count", 8'(count), 8'd0);
        check("ar_alu",   out_alu,   8'd0);
        check("ar_empty", 8'(empty), 8'd1);
        reset = 1'b1;
        pop = 1'b1;
        step();
        idle();
        check("ar_pop_err",   8'(err),   8'd1);
        check("ar_pop_count", 8'(count), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_stack.md
# acc_stack

Parametrised accumulator with a hardware save stack: a WIDTH-bit working accumulator plus DEPTH saved entries that can be pushed and popped. Sits in the datapath where the single accumulator sat. Feeds the ALU continuously and drives the shared register bus only when dumped. Nested or interrupted computations can spill and restore the accumulator without register-file traffic.

## Interface
- WIDTH, 8, data width of accumulator, bus and stack entries (≥1)
- DEPTH, 4, number of saved stack entries below the accumulator (≥2)
- CW, $clog2(DEPTH+1), width of `count` (derived localparam, not overridable)

- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; asserting clears state immediately, release is synchronous to clk
- load  input  1  write `in` into accumulator
- push  input  1  save accumulator onto stack
- pop  input  1  restore accumulator from stack
- dump  input  1  drive accumulator onto `out_reg`
- in  input  WIDTH  data from bus/ALU result
- out_reg  output  WIDTH  bus output, valid only while `dump`=1
- out_alu  output  WIDTH  accumulator value, always driven
- count  output  CW  number of occupied stack entries, 0..DEPTH
- full  output  1  count==DEPTH
- empty  output  1  count==0
- err  output  1  one-cycle pulse flagging an illegal request

## Operation
- State: accumulator `acc`, stack memory `mem[0..DEPTH-1]`, `count`, `err`.
- Per rising edge, evaluated in priority order:
  - push && pop: illegal; no state change; err<=1.
  - push && full: overflow; no state change; err<=1.
  - pop && empty: underflow; no state change; err<=1.
  - push: mem[count]<=acc; count<=count+1; acc<=load ? in : acc (load+push = save old, load new in one cycle).
  - pop: acc<=mem[count-1]; count<=count-1; load ignored (no error).
  - load only: acc<=in.
  - none: hold.
- err<=0 on every edge not matching an illegal case.
- out_alu = acc, combinational from register.
- out_reg = acc when dump=1, otherwise idle value (see Configuration). dump has no effect on state and may coincide with any operation; it shows the pre-edge acc.
- full/empty combinational from registered count.
- Stack memory is not reset; contents above count are don't-care and never observable.

## Timing
- Reset (reset=0): acc=0, count=0, err=0 asynchronously; out_alu=0, empty=1, full=0 immediately.
- load/push/pop latency: 1 clock; new acc visible on out_alu after the edge.
- out_reg follows dump combinationally (zero-cycle).
- err asserted for exactly one cycle following each illegal-request edge; back-to-back illegal requests hold err high continuously.
- Reset mid-sequence discards all saved entries; first op after release sees empty stack.
- Push at count==DEPTH-1 succeeds and sets full; pop at count==1 succeeds and sets empty.

## Configuration
- ACC_STACK_TRISTATE_EN defined: out_reg is all-Z when dump=0 (shared tristate bus).
- Undefined: out_reg is all-0 when dump=0 (mux/OR-bus); all other behaviour identical.

## Test plan
- Reset: hold reset=0 with load=1, in=8'hAA, clock running -> out_alu=0, count=0, empty=1, err=0; after release, one load edge -> out_alu=8'hAA.
- Fill/drain (DEPTH=4): load 1, then push+load with in=2,3,4,5 -> count=4, full=1, out_alu=5; four pops -> out_alu 4,3,2,1, count ends 0, empty=1.
- Overflow/underflow: at full, push -> err=1 for one cycle, count=4, out_alu unchanged; at empty, pop -> err=1, acc unchanged.
- Simultaneous push+pop at count=2 -> err=1, count=2, acc unchanged; pop+load with in=8'hFF at count=1 -> acc=popped value, not 8'hFF, err=0.
- Dump: acc=8'h3C, dump=1 -> out_reg=8'h3C same cycle; dump=0 -> out_reg=8'hZZ with ACC_STACK_TRISTATE_EN, 8'h00 without.
- Async reset mid-operation: count=3, assert reset between edges -> count=0, out_alu=0 before next edge; pop after release -> err=1.
